// File: rtl/moviment_authorization_if.sv
// Bundle of the signals between the scheduler side and the movement
// authorization controller. The master drives the requests and interlocks.
// The slave is the controller, which returns authorization and status.
interface moviment_authorization_if #(
    parameter int NUM_INTERLOCKS = 2
);
    logic                      emergency_mode;
    logic [NUM_INTERLOCKS-1:0] interlocks;
    logic                      move_request;
    logic                      fault_ack;
    logic                      moviment_authorization;
    logic [2:0]                state;
    logic                      fault;
    logic [1:0]                fault_code;

    modport master (
        output emergency_mode, interlocks, move_request, fault_ack,
        input  moviment_authorization, state, fault, fault_code
    );

    modport slave (
        input  emergency_mode, interlocks, move_request, fault_ack,
        output moviment_authorization, state, fault, fault_code
    );
endinterface

// File: rtl/moviment_authorization_ctrl.sv
// Elevator movement authorization controller.
// Movement is granted only after the interlocks and the request have been
// stable for SETTLE_CYCLES. Emergency drops the grant in the same cycle.
// Leaving emergency needs a timed recovery followed by an acknowledge.
// Optional watchdog: define MOVIMENT_WATCHDOG_EN to limit how long the
// controller can stay authorized without a break (fault code 11).
module moviment_authorization_ctrl #(
    parameter int NUM_INTERLOCKS  = 2,
    parameter int SETTLE_CYCLES   = 4,
    parameter int RECOVERY_CYCLES = 8,
    parameter int WATCHDOG_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    moviment_authorization_if.slave        bus
);

    // WATCHDOG_CYCLES only sizes the counters when the watchdog is built in.
`ifdef MOVIMENT_WATCHDOG_EN
    localparam int WD_ACTIVE = WATCHDOG_CYCLES;
`else
    localparam int WD_ACTIVE = 0 * WATCHDOG_CYCLES;
`endif
    localparam int MAX_SR  = (SETTLE_CYCLES > RECOVERY_CYCLES) ? SETTLE_CYCLES : RECOVERY_CYCLES;
    localparam int MAX_ALL = (MAX_SR > WD_ACTIVE) ? MAX_SR : WD_ACTIVE;
    localparam int CNT_W   = $clog2(MAX_ALL) + 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOV_LAST  = CNT_W'(RECOVERY_CYCLES - 1);
`ifdef MOVIMENT_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LAST     = CNT_W'(WATCHDOG_CYCLES - 1);
`endif

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_INTLK = 2'b01;
    localparam logic [1:0] CODE_EMERG = 2'b10;
    localparam logic [1:0] CODE_WDOG  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_AUTH   = 3'd2,
        ST_EMERG  = 3'd3,
        ST_RECOV  = 3'd4
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               fault_reg;
    logic [1:0]         code_reg;
`ifdef MOVIMENT_WATCHDOG_EN
    logic [CNT_W-1:0]   wd_reg;
`endif

    // AND-reduce the interlocks as a chain so any NUM_INTERLOCKS works.
    logic [NUM_INTERLOCKS-1:0] interlocks_w;
    logic [NUM_INTERLOCKS:0]   safe_chain;
    logic                      safe;

    assign interlocks_w  = bus.interlocks;
    assign safe_chain[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < NUM_INTERLOCKS; gi++) begin : g_safe
            assign safe_chain[gi+1] = safe_chain[gi] & interlocks_w[gi];
        end
    endgenerate
    assign safe = safe_chain[NUM_INTERLOCKS];

    // Motor enable is kept combinational so emergency or interlock loss cuts it at once.
    assign bus.moviment_authorization = (state_reg == ST_AUTH) & ~bus.emergency_mode & safe;
    assign bus.state      = state_reg;
    assign bus.fault      = fault_reg;
    assign bus.fault_code = code_reg;

    // Main FSM: emergency overrides everything, otherwise per-state sequencing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            fault_reg <= 1'b0;
            code_reg  <= CODE_NONE;
`ifdef MOVIMENT_WATCHDOG_EN
            wd_reg    <= '0;
`endif
        end else begin
`ifdef MOVIMENT_WATCHDOG_EN
            // The watchdog count only survives an uninterrupted stay in AUTHORIZED.
            wd_reg <= '0;
`endif
            if (bus.emergency_mode) begin
                if (state_reg != ST_EMERG) begin
                    state_reg <= ST_EMERG;
                    cnt_reg   <= '0;
                end
                fault_reg <= 1'b1;
                code_reg  <= CODE_EMERG;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        // Interlock and watchdog faults are cleared by an acknowledge from idle.
                        if (bus.fault_ack && (code_reg == CODE_INTLK || code_reg == CODE_WDOG)) begin
                            fault_reg <= 1'b0;
                            code_reg  <= CODE_NONE;
                        end
                        if (!fault_reg && bus.move_request && safe) begin
                            state_reg <= ST_SETTLE;
                            cnt_reg   <= '0;
                        end
                    end
                    ST_SETTLE: begin
                        if (!bus.move_request || !safe) begin
                            state_reg <= ST_IDLE;
                            cnt_reg   <= '0;
                        end else if (cnt_reg == SETTLE_LAST) begin
                            state_reg <= ST_AUTH;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    ST_AUTH: begin
                        // Interlock loss takes precedence so a simultaneous drop records the fault.
                        if (!safe) begin
                            state_reg <= ST_IDLE;
                            cnt_reg   <= '0;
                            fault_reg <= 1'b1;
                            code_reg  <= CODE_INTLK;
                        end else if (!bus.move_request) begin
                            state_reg <= ST_IDLE;
                            cnt_reg   <= '0;
`ifdef MOVIMENT_WATCHDOG_EN
                        end else if (wd_reg == WD_LAST) begin
                            state_reg <= ST_IDLE;
                            cnt_reg   <= '0;
                            fault_reg <= 1'b1;
                            code_reg  <= CODE_WDOG;
                        end else begin
                            wd_reg <= wd_reg + 1'b1;
`endif
                        end
                    end
                    ST_EMERG: begin
                        state_reg <= ST_RECOV;
                        cnt_reg   <= '0;
                    end
                    ST_RECOV: begin
                        if (bus.fault_ack && cnt_reg == RECOV_LAST) begin
                            state_reg <= ST_IDLE;
                            cnt_reg   <= '0;
                            fault_reg <= 1'b0;
                            code_reg  <= CODE_NONE;
                        end else if (cnt_reg != RECOV_LAST) begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/moviment_authorization_ctrl.md
Name: moviment_authorization_ctrl

Overview:
Parametrised, stateful successor to the elevator movement-authorization gate. It grants movement only after all safety interlocks have been stable for a settle window. Emergency mode drops authorization in the same cycle, and re-arming after an emergency requires a timed recovery plus an explicit acknowledge. Sits between the call/scheduling logic (move_request) and the motor drive (moviment_authorization).

Parameters:
NUM_INTERLOCKS, 2, number of safety interlock inputs (door closed, no overload, ...); all must be 1 to move
SETTLE_CYCLES, 4, cycles interlocks + request must hold before authorization; >= 1
RECOVERY_CYCLES, 8, cycles emergency_mode must stay low before acknowledge is accepted; >= 1
WATCHDOG_CYCLES, 64, max continuous authorized cycles (only with optional feature)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
emergency_mode  input  1  emergency request, highest priority
interlocks  input  NUM_INTERLOCKS  safety conditions, 1 = safe
move_request  input  1  level request to move from scheduler
fault_ack  input  1  operator/controller acknowledge, single-cycle pulse
moviment_authorization  output  1  motor enable
state  output  3  current FSM state encoding
fault  output  1  sticky fault flag
fault_code  output  2  00 none, 01 interlock lost while moving, 10 emergency, 11 watchdog

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, fault=0, fault_code=00, moviment_authorization=0.
- States and encodings: IDLE=0, SETTLE=1, AUTHORIZED=2, EMERGENCY=3, RECOVERY=4. Unused encodings go to IDLE.
- safe = &interlocks.
- moviment_authorization = (state==AUTHORIZED) & ~emergency_mode & safe. This path is combinational: a drop is visible in the same cycle as the cause, with no registered delay.
- Emergency priority: in any state, emergency_mode=1 causes next state EMERGENCY and fault=1. fault_code becomes 10 unless it is already 10.
- IDLE:
  - fault_ack=1 clears fault and fault_code when the code is 01 or 11.
  - If fault=0 & move_request & safe: go to SETTLE with counter=0.
  - While fault=1, move_request is ignored.
- SETTLE:
  - counter increments each cycle.
  - If ~move_request or ~safe: go to IDLE (no fault).
  - When counter==SETTLE_CYCLES-1 with conditions still met: go to AUTHORIZED. Authorization is high exactly SETTLE_CYCLES cycles after the SETTLE entry edge.
- AUTHORIZED:
  - ~move_request: go to IDLE, no fault.
  - ~safe: go to IDLE with fault=1, fault_code=01.
  - If both drop in the same cycle, the fault is recorded.
- EMERGENCY: hold while emergency_mode=1. On emergency_mode=0, go to RECOVERY with counter=0.
- RECOVERY:
  - counter saturates at RECOVERY_CYCLES-1.
  - emergency_mode=1 returns to EMERGENCY and discards the count.
  - fault_ack while counter < RECOVERY_CYCLES-1 is ignored.
  - fault_ack once saturated: go to IDLE with fault=0, fault_code=00.
- Counter width is $clog2 of the largest active cycle parameter, plus 1. It is shared between states and cleared on every state entry.
- Reset mid-operation: all outputs drop immediately, including during EMERGENCY. After reset the emergency latch is lost, so the upstream emergency_mode level re-enters EMERGENCY on the next edge if it is still high.

Optional Feature:
MOVIMENT_WATCHDOG_EN:
- Defined: a dedicated counter runs while in AUTHORIZED. Reaching WATCHDOG_CYCLES-1 forces IDLE with fault=1, fault_code=11. The counter clears on leaving AUTHORIZED.
- Undefined: no watchdog counter, WATCHDOG_CYCLES is unused, fault_code 11 is never produced.

Test Plan:
- Reset, then move_request=1, interlocks=2'b11 held -> moviment_authorization rises exactly 4 cycles after entering SETTLE. state sequence 0,1,1,1,1,2.
- AUTHORIZED, emergency_mode=1 mid-cycle -> moviment_authorization=0 in the same cycle (before the next edge). Next state 3, fault=1, fault_code=10.
- Emergency released, fault_ack pulsed at recovery cycle 3 -> ignored, state stays 4. fault_ack at cycle 8 -> state 0, fault=0. Emergency re-asserted at recovery cycle 5 -> back to state 3.
- interlocks=2'b01 during SETTLE at cycle 2 -> state 0, fault=0. interlocks=2'b10 during AUTHORIZED -> authorization 0 same cycle, state 0, fault_code=01. move_request is then blocked until fault_ack.
- Async reset asserted in AUTHORIZED between clock edges -> outputs 0 immediately, state 0.
- With MOVIMENT_WATCHDOG_EN, hold AUTHORIZED 64 cycles -> state 0, fault_code=11. Without the macro -> remains authorized at cycle 200.
